// File: rtl/if_stage_fifo.sv
// Merged pre-IF/IF fetch stage that buffers SRAM responses in a FIFO_DEPTH-entry instruction FIFO.
// Optional feature macro IF_ADDR_MAP_EN: translate kseg0/kseg1/kuseg fetch addresses before the SRAM.
module if_stage_fifo #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = 32'hbfc0_0000,
  parameter logic [31:0] EX_VEC          = 32'hbfc0_0380,
  parameter int unsigned FS_TO_DS_BUS_WD = 66
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [32:0]                br_bus,
  input  logic                       br_stall,
  input  logic                       bd_from_ds,
  input  logic                       ex_from_ws,
  input  logic                       eret_from_ws,
  input  logic [31:0]                cp0_epc,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_wen,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata,
  output logic                       fs_valid_h
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [0:0] {RUN = 1'b0, WAIT_DS = 1'b1} state_e;

  logic [64:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d, tgt_q, tgt_d;
  logic          inflight_q, inflight_d;
  state_e        state_q, state_d;
  logic          nonempty_s, pop_s, push_s, discard_s, issue_s, br_now_s, br_wait_s;
  logic [31:0]   fetch_pc_s;
  logic [CW:0]   occupancy_s;
  logic [64:0]   head_s;

  function automatic logic [31:0] map_addr(input logic [31:0] va);
`ifdef IF_ADDR_MAP_EN
    if (va[31:30] == 2'b10) begin
      map_addr = {3'b000, va[28:0]};
    end else if (va[31] == 1'b0) begin
      map_addr = {((va[30] == 1'b0) ? 2'b01 : 2'b10), va[29:0]};
    end else begin
      map_addr = va;
    end
`else
    map_addr = va;
`endif
  endfunction

  always_comb begin
    nonempty_s  = (count_q != {CW{1'b0}});
    pop_s       = nonempty_s && ds_allowin;
    // A redirect is immediate once something after the branch exists; otherwise wait for the delay slot.
    br_now_s    = br_bus[32] && !ex_from_ws && (state_q == RUN) && (nonempty_s || inflight_q);
    br_wait_s   = br_bus[32] && !ex_from_ws && (state_q == RUN) && !nonempty_s && !inflight_q;
    discard_s   = ex_from_ws || (br_now_s && nonempty_s);
    push_s      = inflight_q && !discard_s;
    fetch_pc_s  = br_now_s ? br_bus[31:0] : pc_q;
    occupancy_s = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue_s     = !reset && !br_stall && !ex_from_ws && (occupancy_s < (CW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = (br_wait_s && !issue_s) ? WAIT_DS : RUN;
      WAIT_DS: state_d = (ex_from_ws || issue_s) ? RUN : WAIT_DS;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    tgt_d      = tgt_q;
    inflight_d = issue_s;
    if (ex_from_ws) begin
      pc_d = eret_from_ws ? cp0_epc : EX_VEC;
    end else if (issue_s) begin
      // The request issued alongside a deferred branch is the delay slot; the target follows it.
      req_pc_d = fetch_pc_s;
      if (state_q == WAIT_DS) begin
        pc_d = tgt_q;
      end else if (br_wait_s) begin
        pc_d = br_bus[31:0];
      end else begin
        pc_d = fetch_pc_s + 32'd4;
      end
    end else if (br_now_s) begin
      pc_d = br_bus[31:0];
    end else if (br_wait_s) begin
      tgt_d = br_bus[31:0];
    end else begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (ex_from_ws) begin
      wr_ptr_d = rd_ptr_q;
      count_d  = {CW{1'b0}};
    end else if (br_now_s && pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
      wr_ptr_d = rd_ptr_q + AW'(1'b1);
      count_d  = {CW{1'b0}};
    end else if (br_now_s && nonempty_s) begin
      wr_ptr_d = rd_ptr_q + AW'(1'b1);
      count_d  = CW'(1'b1);
    end else begin
      wr_ptr_d = push_s ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'd0;
      tgt_q      <= 32'd0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      tgt_q      <= tgt_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 65'd0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= {(req_pc_q[1:0] != 2'b00), inst_sram_rdata, req_pc_q};
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  always_comb begin
    head_s          = mem_q[rd_ptr_q];
    fs_to_ds_valid  = nonempty_s;
    fs_valid_h      = nonempty_s;
    fs_to_ds_bus    = nonempty_s ? {(bd_from_ds && !head_s[64]), head_s} : {FS_TO_DS_BUS_WD{1'b0}};
    inst_sram_en    = issue_s;
    inst_sram_wen   = 4'd0;
    inst_sram_wdata = 32'd0;
    inst_sram_addr  = reset ? 32'd0 : map_addr(fetch_pc_s);
  end
endmodule

// File: tb/tb_if_stage_fifo.sv
// Directed bench for if_stage_fifo: queue-based fetch model checked every cycle plus literal expectations.
module tb_if_stage_fifo;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] KEY    = 32'h1234_5678;
  localparam logic [31:0] EX_VEC = 32'hbfc0_0380;
`ifdef IF_ADDR_MAP_EN
  localparam logic [31:0] FIRST_ADDR = 32'h1fc0_0000;
`else
  localparam logic [31:0] FIRST_ADDR = 32'hbfc0_0000;
`endif

  typedef struct packed {logic ex; logic [31:0] inst; logic [31:0] pc;} ent_t;

  logic        clk, reset, ds_allowin, br_stall, bd_from_ds, ex_from_ws, eret_from_ws;
  logic [32:0] br_bus;
  logic [31:0] cp0_epc, inst_sram_rdata, inst_sram_addr, inst_sram_wdata;
  logic        fs_to_ds_valid, inst_sram_en, fs_valid_h;
  logic [65:0] fs_to_ds_bus;
  logic [3:0]  inst_sram_wen;

  int n_pass, n_tot, nreq;
  logic [31:0] pops[$];
  logic        pend_en;
  logic [31:0] pend_addr;

  ent_t        mq[$];
  logic [31:0] m_pc, m_infl_pc, m_tgt, fetch;
  logic        m_infl, m_wait, br_eff, now_b, exp_en, pop_b, keep;
  int          s0;
  ent_t        resp;

  if_stage_fifo dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus), .br_stall(br_stall),
    .bd_from_ds(bd_from_ds), .ex_from_ws(ex_from_ws), .eret_from_ws(eret_from_ws), .cp0_epc(cp0_epc),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus), .inst_sram_en(inst_sram_en),
    .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata), .fs_valid_h(fs_valid_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] phys(input logic [31:0] va);
`ifdef IF_ADDR_MAP_EN
    if (va >= 32'h8000_0000 && va < 32'hc000_0000) return va & 32'h1fff_ffff;
    if (va < 32'h8000_0000) return va + 32'h4000_0000;
    return va;
`else
    return va;
`endif
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic alw, input logic bd, input logic stall, input logic brt,
                       input logic [31:0] tgt, input logic ex, input logic eret, input logic [31:0] epc);
    ds_allowin = alw; bd_from_ds = bd; br_stall = stall; br_bus = {brt, tgt};
    ex_from_ws = ex; eret_from_ws = eret; cp0_epc = epc;
  endtask

  // Advance one cycle; the SRAM answers the request seen just before the edge.
  task automatic tick();
    @(negedge clk); #3;
    pend_en = inst_sram_en; pend_addr = inst_sram_addr;
    @(posedge clk); #1;
    inst_sram_rdata = pend_en ? (pend_addr ^ KEY) : 32'hffff_ffff;
  endtask

  task automatic run(input int n, input logic alw);
    for (int i = 0; i < n; i++) begin
      drive(alw, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
    end
  endtask

  // Per-cycle compare against the queue model, then advance the model across the coming edge.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      mq.delete(); m_pc = 32'hbfc0_0000; m_infl = 1'b0; m_wait = 1'b0;
      check("rst_en", inst_sram_en, 66'd0);
      check("rst_valid", fs_to_ds_valid, 66'd0);
      check("rst_valid_h", fs_valid_h, 66'd0);
      check("rst_addr", inst_sram_addr, 66'd0);
      check("rst_bus", fs_to_ds_bus, 66'd0);
    end else begin
      s0     = mq.size();
      br_eff = br_bus[32] && !ex_from_ws && !m_wait;
      now_b  = br_eff && (s0 != 0 || m_infl);
      fetch  = now_b ? br_bus[31:0] : m_pc;
      exp_en = !br_stall && !ex_from_ws && ((s0 + int'(m_infl)) < DEPTH);
      check("en", inst_sram_en, exp_en);
      if (exp_en) check("addr", inst_sram_addr, phys(fetch));
      check("wen", inst_sram_wen, 66'd0);
      check("valid", fs_to_ds_valid, s0 != 0);
      check("valid_h", fs_valid_h, s0 != 0);
      if (s0 != 0) begin
        check("head_pc", fs_to_ds_bus[31:0], mq[0].pc);
        check("head_inst", fs_to_ds_bus[63:32], mq[0].inst);
        check("head_ex", fs_to_ds_bus[64], mq[0].ex);
        check("head_bd", fs_to_ds_bus[65], bd_from_ds && !mq[0].ex);
      end
      pop_b = (s0 != 0) && ds_allowin;
      resp  = '{ex: (m_infl_pc[1:0] != 2'b00), inst: phys(m_infl_pc) ^ KEY, pc: m_infl_pc};
      if (ex_from_ws) begin
        mq.delete(); m_infl = 1'b0; m_wait = 1'b0;
        m_pc = eret_from_ws ? cp0_epc : EX_VEC;
      end else begin
        keep = m_infl;
        if (pop_b) void'(mq.pop_front());
        if (br_eff && s0 != 0) begin
          keep = 1'b0;
          if (pop_b) mq.delete();
          else while (mq.size() > 1) mq.delete(mq.size() - 1);
        end
        if (keep) mq.push_back(resp);
        if (exp_en) begin
          m_infl = 1'b1; m_infl_pc = fetch;
          if (m_wait) m_pc = m_tgt;
          else if (br_eff && !now_b) m_pc = br_bus[31:0];
          else m_pc = fetch + 32'd4;
          m_wait = 1'b0;
        end else begin
          m_infl = 1'b0;
          if (now_b) m_pc = br_bus[31:0];
          else if (br_eff) begin m_wait = 1'b1; m_tgt = br_bus[31:0]; end
        end
      end
    end
  end

  initial begin
    n_pass = 0; n_tot = 0; inst_sram_rdata = 32'h0; reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); tick();

    // Reset release: back-to-back sequential fetch, head appears two cycles after the first request.
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("lit_first_en", inst_sram_en, 66'd1);
    check("lit_first_addr", inst_sram_addr, FIRST_ADDR);
    tick(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("lit_addr_04", inst_sram_addr, FIRST_ADDR + 32'd4);
    check("lit_valid_early", fs_to_ds_valid, 66'd0);
    tick(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("lit_addr_08", inst_sram_addr, FIRST_ADDR + 32'd8);
    check("lit_head_valid", fs_to_ds_valid, 66'd1);
    check("lit_head_pc", fs_to_ds_bus[31:0], 32'hbfc0_0000);
    tick();
    run(3, 1'b1);

    // Decode stalled: exactly DEPTH requests, then in-order drain.
    reset = 1'b1; tick(); reset = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
      if (inst_sram_en) nreq++;
      tick();
    end
    check("lit_stall_reqs", nreq, 66'd4);
    pops.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
      if (fs_to_ds_valid) pops.push_back(fs_to_ds_bus[31:0]);
      tick();
    end
    check("lit_pop_count", pops.size() >= 5, 66'd1);
    if (pops.size() >= 5)
      for (int k = 0; k < 5; k++) check("lit_pop_order", pops[k], 32'hbfc0_0000 + 32'(4 * k));

    // Branch with three buffered entries and no pop: keep the delay slot only.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100); tick();
    run(4, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0); #1;
    check("lit_br_head_pc", fs_to_ds_bus[31:0], 32'h0000_0100);
    check("lit_br_bd", fs_to_ds_bus[65], 66'd1);
    check("lit_br_full_en", inst_sram_en, 66'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("lit_br_target_addr", inst_sram_addr, phys(32'h0000_0200));
    check("lit_br_kept_head", fs_to_ds_bus[31:0], 32'h0000_0100);
    tick();
    run(3, 1'b1);

    // Branch with nothing buffered or in flight: delay slot 0x104 first, then 0x300; second branch ignored.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0104); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0); #1;
    check("lit_wds_stall_en", inst_sram_en, 66'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0); #1;
    check("lit_wds_slot_addr", inst_sram_addr, phys(32'h0000_0104));
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("lit_wds_target_addr", inst_sram_addr, phys(32'h0000_0300));
    tick();

    // Flush with a full FIFO and a simultaneous branch, then eret.
    run(5, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'h0); #1;
    check("lit_full_valid", fs_to_ds_valid, 66'd1);
    check("lit_flush_en", inst_sram_en, 66'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("lit_flush_empty", fs_to_ds_valid, 66'd0);
    check("lit_exvec_addr", inst_sram_addr, phys(32'hbfc0_0380));
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_1000); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("lit_eret_addr", inst_sram_addr, phys(32'h8000_1000));
    tick();

    // Branch on a popping head to a misaligned target: entry tagged ex, bd suppressed.
    run(1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0202, 1'b0, 1'b0, 32'h0); #1;
    check("lit_mis_addr", inst_sram_addr, phys(32'h0000_0202));
    tick();
    run(1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); #1;
    check("lit_mis_pc", fs_to_ds_bus[31:0], 32'h0000_0202);
    check("lit_mis_ex", fs_to_ds_bus[64], 66'd1);
    check("lit_mis_bd", fs_to_ds_bus[65], 66'd0);
    tick();
    run(6, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
